trap_ctrl: RTL and testbench
============================

# trap_ctrl

Machine-mode trap sequencer for the RV32 core. It recognises ECALL, EBREAK and MRET in the execute stage, and gated machine-timer interrupts. It then performs the required CSR updates (mepc, mcause, mstatus) one per cycle through a dedicated CSR write port, which has priority over the pipeline's port at csr_file. It holds and flushes the pipeline via pipe_ctrl while busy and issues the final redirect to mtvec or mepc.

## Interface
- ADDR_WIDTH, 32, instruction address width
- DATA_WIDTH, 32, CSR/register data width
- CSR_ADDR_WIDTH, 12, CSR address width

- clk_i  in  1  core clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- inst_i  in  32  instruction currently in exe (from id_exe)
- inst_addr_i  in  ADDR_WIDTH  address of inst_i
- stall_i  in  1  exe stall request (mult/div busy)
- jump_pending_i  in  1  exe branch/jump redirect asserted this cycle
- mem_csr_we_i  in  1  CSR write in flight in mem stage
- irq_timer_i  in  1  machine timer interrupt, level
- csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i  in  DATA_WIDTH  current CSR values from csr_file
- csr_we_o  out  1  CSR write enable (priority port)
- csr_waddr_o  out  CSR_ADDR_WIDTH  CSR write address
- csr_wdata_o  out  DATA_WIDTH  CSR write data
- hold_o  out  1  to pipe_ctrl: flush id_exe/exe_mem, freeze PC
- jump_enable_o  out  1  redirect strobe to pipe_ctrl
- jump_addr_o  out  ADDR_WIDTH  redirect target

## Operation
- Decode in IDLE:
  - ECALL = 0x00000073, cause 11
  - EBREAK = 0x00100073, cause 3
  - MRET = 0x30200073
  - IRQ = irq_timer_i & mstatus[3] (MIE) & mie[7] (MTIE), cause 0x80000007
- Acceptance requires stall_i=0, jump_pending_i=0 and mem_csr_we_i=0. Otherwise defer, re-evaluating each cycle.
- Priority: ECALL/EBREAK/MRET over IRQ. IRQ is level, so it stays pending and is taken after the synchronous event completes if still enabled.
- On accept:
  - latch cause and epc = inst_addr_i
  - assert hold_o combinationally the same cycle, so the exe instruction is killed
  - for IRQ the killed instruction re-executes after MRET
- FSM states: IDLE, W_MEPC, W_MCAUSE, W_MSTAT, W_MRET, JUMP.
  - Trap path: IDLE -> W_MEPC -> W_MCAUSE -> W_MSTAT -> JUMP -> IDLE.
  - MRET path: IDLE -> W_MRET -> JUMP -> IDLE.
- W_MEPC: write 0x341 with {epc[31:2],2'b00}.
- W_MCAUSE: write 0x342 with the latched cause.
- W_MSTAT: write 0x300 with MPIE(bit7) <= MIE(bit3), MIE <= 0, MPP(12:11) <= 2'b11, other bits unchanged.
- W_MRET: write 0x300 with MIE <= MPIE, MPIE <= 1, MPP <= 2'b11, other bits unchanged.
- JUMP, trap path: jump_enable_o=1, jump_addr_o={mtvec[31:2],2'b00} (direct mode only).
- JUMP, MRET path: jump_enable_o=1, jump_addr_o=mepc.
- hold_o=1 in every non-IDLE state and in the IDLE accept cycle.
- csr_we_o=1 only in the W_* states. csr_waddr_o and csr_wdata_o are 0 when csr_we_o=0.

## Timing
- Reset (rst_i=0, async): state=IDLE, latched cause/epc=0, all outputs 0. Reset mid-sequence aborts with no further CSR writes.
- Outputs are registered-state decodes, except hold_o in the accept cycle, which is combinational from inputs.
- Trap, accept at cycle T:
  - mepc write T+1, mcause T+2, mstatus T+3
  - jump_enable_o at T+4, one cycle
  - IDLE at T+5; earliest next accept T+5
- MRET, accept at T: mstatus write T+1, jump_enable_o T+2, IDLE T+3.
- CSR writes are visible at csr_*_i the cycle after the write. MRET reads MPIE from csr_mstatus_i in W_MRET.
- Inputs are ignored outside IDLE. An irq_timer_i edge during a sequence does not pre-empt it.

## Test plan
- ECALL at 0x00000104, mtvec=0x00000200, mstatus=0x8:
  - mepc=0x104 at T+1, mcause=11 at T+2, mstatus=0x1880 at T+3
  - jump to 0x200 at T+4; hold_o high T..T+4
- MRET with mepc=0x108, mstatus=0x1880: mstatus=0x1888 at T+1, jump to 0x108 at T+2.
- irq_timer_i=1 with mie=0x80, mstatus=0x8, exe inst at 0x120: mcause=0x80000007, mepc=0x120, jump to mtvec. With mstatus=0x0: no accept, hold_o stays 0.
- EBREAK arrives while stall_i=1 for 3 cycles: no accept until stall_i falls, then mcause=3. Same deferral for jump_pending_i and mem_csr_we_i.
- ECALL and irq in the same cycle: ECALL sequence first. After its jump, MIE=0, so the IRQ is not taken until MRET restores MIE, then it is taken.
- rst_i low at T+2 of a trap: outputs 0 immediately, no mstatus write, no jump; FSM in IDLE after release.

Source files
------------

// File: rtl/trap_ctrl_if.sv
// Signal bundle between the exe/mem pipeline, csr_file, pipe_ctrl and trap_ctrl.
// The slave modport is the trap sequencer's view; the master modport is the surrounding core's.
interface trap_ctrl_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12
);
    logic [31:0]               inst;
    logic [ADDR_WIDTH-1:0]     inst_addr;
    logic                      stall;
    logic                      jump_pending;
    logic                      mem_csr_we;
    logic                      irq_timer;
    logic [DATA_WIDTH-1:0]     csr_mstatus;
    logic [DATA_WIDTH-1:0]     csr_mie;
    logic [DATA_WIDTH-1:0]     csr_mtvec;
    logic [DATA_WIDTH-1:0]     csr_mepc;
    logic                      csr_we;
    logic [CSR_ADDR_WIDTH-1:0] csr_waddr;
    logic [DATA_WIDTH-1:0]     csr_wdata;
    logic                      hold;
    logic                      jump_enable;
    logic [ADDR_WIDTH-1:0]     jump_addr;

    modport master (
        output inst, inst_addr, stall, jump_pending, mem_csr_we, irq_timer,
        output csr_mstatus, csr_mie, csr_mtvec, csr_mepc,
        input  csr_we, csr_waddr, csr_wdata, hold, jump_enable, jump_addr
    );

    modport slave (
        input  inst, inst_addr, stall, jump_pending, mem_csr_we, irq_timer,
        input  csr_mstatus, csr_mie, csr_mtvec, csr_mepc,
        output csr_we, csr_waddr, csr_wdata, hold, jump_enable, jump_addr
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes ECALL/EBREAK/MRET and the gated timer interrupt,
// writes mepc/mcause/mstatus one per cycle, then redirects the pipeline.
//
// state    | meaning
// IDLE     | watching exe; accepts a trap/MRET when the pipeline is quiet
// W_MEPC   | writing mepc with the latched epc
// W_MCAUSE | writing mcause with the latched cause
// W_MSTAT  | trap entry mstatus update (MPIE<=MIE, MIE<=0, MPP<=M)
// W_MRET   | MRET mstatus update (MIE<=MPIE, MPIE<=1, MPP<=M)
// JUMP     | one-cycle redirect to mtvec (trap) or mepc (MRET)
module trap_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12
) (
    input logic       clk,
    input logic       rst_n,
    trap_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, W_MEPC, W_MCAUSE, W_MSTAT, W_MRET, JUMP
    } state_t;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] cause_q, cause_nxt;
    logic [ADDR_WIDTH-1:0] epc_q, epc_nxt;
    logic                  mret_q, mret_nxt;
    logic [DATA_WIDTH-1:0] mst;

    logic is_ecall, is_ebreak, is_mret, irq_en, quiet, accept;

    assign is_ecall  = (bus.inst == INST_ECALL);
    assign is_ebreak = (bus.inst == INST_EBREAK);
    assign is_mret   = (bus.inst == INST_MRET);
    assign irq_en    = bus.irq_timer & bus.csr_mstatus[3] & bus.csr_mie[7];
    assign quiet     = ~bus.stall & ~bus.jump_pending & ~bus.mem_csr_we;
    // rst_n gates the combinational accept so hold stays low while in reset
    assign accept    = rst_n & quiet & (is_ecall | is_ebreak | is_mret | irq_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cause_q <= '0;
            epc_q   <= '0;
            mret_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
            epc_q   <= epc_nxt;
            mret_q  <= mret_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cause_nxt       = cause_q;
        epc_nxt         = epc_q;
        mret_nxt        = mret_q;
        mst             = bus.csr_mstatus;
        bus.hold        = 1'b0;
        bus.csr_we      = 1'b0;
        bus.csr_waddr   = '0;
        bus.csr_wdata   = '0;
        bus.jump_enable = 1'b0;
        bus.jump_addr   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    bus.hold = 1'b1;
                    epc_nxt  = bus.inst_addr;
                    if (is_mret) begin
                        state_nxt = W_MRET;
                        mret_nxt  = 1'b1;
                    end else begin
                        state_nxt = W_MEPC;
                        mret_nxt  = 1'b0;
                        if (is_ecall)
                            cause_nxt = DATA_WIDTH'(32'd11);
                        else if (is_ebreak)
                            cause_nxt = DATA_WIDTH'(32'd3);
                        else
                            cause_nxt = DATA_WIDTH'(32'h8000_0007);
                    end
                end
            end
            W_MEPC: begin
                bus.hold      = 1'b1;
                bus.csr_we    = 1'b1;
                bus.csr_waddr = CSR_ADDR_WIDTH'(12'h341);
                bus.csr_wdata = DATA_WIDTH'({epc_q[ADDR_WIDTH-1:2], 2'b00});
                state_nxt     = W_MCAUSE;
            end
            W_MCAUSE: begin
                bus.hold      = 1'b1;
                bus.csr_we    = 1'b1;
                bus.csr_waddr = CSR_ADDR_WIDTH'(12'h342);
                bus.csr_wdata = cause_q;
                state_nxt     = W_MSTAT;
            end
            W_MSTAT: begin
                mst[7]        = bus.csr_mstatus[3];
                mst[3]        = 1'b0;
                mst[12:11]    = 2'b11;
                bus.hold      = 1'b1;
                bus.csr_we    = 1'b1;
                bus.csr_waddr = CSR_ADDR_WIDTH'(12'h300);
                bus.csr_wdata = mst;
                state_nxt     = JUMP;
            end
            W_MRET: begin
                mst[3]        = bus.csr_mstatus[7];
                mst[7]        = 1'b1;
                mst[12:11]    = 2'b11;
                bus.hold      = 1'b1;
                bus.csr_we    = 1'b1;
                bus.csr_waddr = CSR_ADDR_WIDTH'(12'h300);
                bus.csr_wdata = mst;
                state_nxt     = JUMP;
            end
            JUMP: begin
                bus.hold        = 1'b1;
                bus.jump_enable = 1'b1;
                if (mret_q)
                    bus.jump_addr = ADDR_WIDTH'(bus.csr_mepc);
                else
                    bus.jump_addr = ADDR_WIDTH'({bus.csr_mtvec[DATA_WIDTH-1:2], 2'b00});
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a tiny CSR register model feeds back the sequencer's writes,
// and every expected value below is a hand-computed constant.
module tb_trap_ctrl;
   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] mstatus, mie, mtvec, mepc, mcause;
   logic        pw;
   logic [11:0] pa;
   logic [31:0] pd;

   trap_ctrl_if bus ();

   trap_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.csr_mstatus = mstatus;
   assign bus.csr_mie     = mie;
   assign bus.csr_mtvec   = mtvec;
   assign bus.csr_mepc    = mepc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
      end
   endtask

   // Advance one cycle; writes seen on the priority port land in the CSR model at the edge.
   task automatic cyc();
      @(negedge clk);
      pw = bus.csr_we;
      pa = bus.csr_waddr;
      pd = bus.csr_wdata;
      @(posedge clk);
      #1;
      if (pw) begin
         case (pa)
            12'h300: mstatus = pd;
            12'h341: mepc    = pd;
            12'h342: mcause  = pd;
            default: ;
         endcase
      end
   endtask

   task automatic accept(input string tag, input logic [31:0] i, input logic [31:0] a);
      bus.inst      = i;
      bus.inst_addr = a;
      #1;
      check({tag, ".hold"}, bus.hold, 1);
      check({tag, ".we"}, bus.csr_we, 0);
      check({tag, ".jmp"}, bus.jump_enable, 0);
      cyc();
      bus.inst = NOP;
   endtask

   task automatic exp_wr(input string tag, input logic [11:0] a, input logic [31:0] d);
      #1;
      check({tag, ".we"}, bus.csr_we, 1);
      check({tag, ".addr"}, bus.csr_waddr, a);
      check({tag, ".data"}, bus.csr_wdata, d);
      check({tag, ".hold"}, bus.hold, 1);
      check({tag, ".jmp"}, bus.jump_enable, 0);
      cyc();
   endtask

   task automatic exp_jmp(input string tag, input logic [31:0] a);
      #1;
      check({tag, ".en"}, bus.jump_enable, 1);
      check({tag, ".addr"}, bus.jump_addr, a);
      check({tag, ".we"}, bus.csr_we, 0);
      check({tag, ".waddr"}, bus.csr_waddr, 0);
      check({tag, ".wdata"}, bus.csr_wdata, 0);
      check({tag, ".hold"}, bus.hold, 1);
      cyc();
   endtask

   task automatic exp_idle(input string tag);
      #1;
      check({tag, ".hold"}, bus.hold, 0);
      check({tag, ".we"}, bus.csr_we, 0);
      check({tag, ".jmp"}, bus.jump_enable, 0);
      cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      pw                = 1'b0;
      pa                = '0;
      pd                = '0;
      rst_n             = 1'b0;
      bus.inst          = ECALL;
      bus.inst_addr     = 32'h100;
      bus.stall         = 1'b0;
      bus.jump_pending  = 1'b0;
      bus.mem_csr_we    = 1'b0;
      bus.irq_timer     = 1'b0;
      mstatus           = 32'h8;
      mie               = 32'h0;
      mtvec             = 32'h200;
      mepc              = 32'h0;
      mcause            = 32'h0;

      // reset: everything quiet even with ECALL in exe
      #2;
      check("rst.hold", bus.hold, 0);
      check("rst.we", bus.csr_we, 0);
      check("rst.waddr", bus.csr_waddr, 0);
      check("rst.wdata", bus.csr_wdata, 0);
      check("rst.jmp", bus.jump_enable, 0);
      check("rst.jaddr", bus.jump_addr, 0);
      bus.inst = NOP;
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_idle("post_rst");

      // ECALL at 0x104
      accept("ecall", ECALL, 32'h104);
      exp_wr("ecall.mepc", 12'h341, 32'h104);
      exp_wr("ecall.mcause", 12'h342, 32'd11);
      exp_wr("ecall.mstat", 12'h300, 32'h1880);
      exp_jmp("ecall.jump", 32'h200);
      exp_idle("ecall.done");
      check("ecall.mstatus_csr", mstatus, 32'h1880);

      // MRET back to 0x108
      mepc    = 32'h108;
      mstatus = 32'h1880;
      accept("mret", MRET, 32'h300);
      exp_wr("mret.mstat", 12'h300, 32'h1888);
      exp_jmp("mret.jump", 32'h108);
      exp_idle("mret.done");

      // timer interrupt, mtvec low bits must be dropped
      mstatus       = 32'h8;
      mie           = 32'h80;
      mtvec         = 32'h203;
      bus.irq_timer = 1'b1;
      accept("irq", NOP, 32'h120);
      exp_wr("irq.mepc", 12'h341, 32'h120);
      exp_wr("irq.mcause", 12'h342, 32'h8000_0007);
      exp_wr("irq.mstat", 12'h300, 32'h1880);
      exp_jmp("irq.jump", 32'h200);
      exp_idle("irq.masked");
      mstatus = 32'h0;
      repeat (2) exp_idle("irq.mie0");
      mstatus = 32'h8;
      mie     = 32'h0;
      exp_idle("irq.mtie0");
      mie           = 32'h80;
      bus.irq_timer = 1'b0;
      mtvec         = 32'h200;
      exp_idle("irq.off");

      // EBREAK deferred by each blocker in turn
      for (int k = 0; k < 3; k++) begin
         mstatus          = 32'h8;
         bus.inst         = EBREAK;
         bus.inst_addr    = 32'h160 + 32'(4 * k);
         bus.stall        = (k == 0);
         bus.jump_pending = (k == 1);
         bus.mem_csr_we   = (k == 2);
         repeat (3) exp_idle($sformatf("defer%0d.wait", k));
         bus.stall        = 1'b0;
         bus.jump_pending = 1'b0;
         bus.mem_csr_we   = 1'b0;
         accept($sformatf("defer%0d", k), EBREAK, 32'h160 + 32'(4 * k));
         exp_wr($sformatf("defer%0d.mepc", k), 12'h341, 32'h160 + 32'(4 * k));
         exp_wr($sformatf("defer%0d.mcause", k), 12'h342, 32'd3);
         exp_wr($sformatf("defer%0d.mstat", k), 12'h300, 32'h1880);
         exp_jmp($sformatf("defer%0d.jump", k), 32'h200);
      end
      exp_idle("defer.done");

      // ECALL and interrupt together: ECALL first, IRQ only after MRET re-enables MIE
      mstatus       = 32'h8;
      mie           = 32'h80;
      bus.irq_timer = 1'b1;
      accept("both", ECALL, 32'h140);
      exp_wr("both.mepc", 12'h341, 32'h140);
      exp_wr("both.mcause", 12'h342, 32'd11);
      exp_wr("both.mstat", 12'h300, 32'h1880);
      exp_jmp("both.jump", 32'h200);
      repeat (2) exp_idle("both.masked");
      accept("both.mret", MRET, 32'h200);
      exp_wr("both.mret_mstat", 12'h300, 32'h1888);
      exp_jmp("both.mret_jump", 32'h140);
      accept("both.irq", NOP, 32'h140);
      exp_wr("both.irq_mepc", 12'h341, 32'h140);
      exp_wr("both.irq_mcause", 12'h342, 32'h8000_0007);
      exp_wr("both.irq_mstat", 12'h300, 32'h1880);
      exp_jmp("both.irq_jump", 32'h200);
      bus.irq_timer = 1'b0;
      exp_idle("both.done");

      // reset in the middle of a trap sequence
      mstatus = 32'h8;
      accept("rstmid", ECALL, 32'h180);
      exp_wr("rstmid.mepc", 12'h341, 32'h180);
      rst_n = 1'b0;
      #1;
      check("rstmid.we", bus.csr_we, 0);
      check("rstmid.waddr", bus.csr_waddr, 0);
      check("rstmid.wdata", bus.csr_wdata, 0);
      check("rstmid.hold", bus.hold, 0);
      check("rstmid.jmp", bus.jump_enable, 0);
      cyc();
      cyc();
      rst_n = 1'b1;
      repeat (4) exp_idle("rstmid.after");
      check("rstmid.mstatus_csr", mstatus, 32'h8);
      check("rstmid.mepc_csr", mepc, 32'h180);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
